// File: rtl/instr_fetch_pkg.sv
// Shared word-size definitions and helpers for the instruction fetch unit.
package instr_fetch_pkg;

   localparam int unsigned WORD_SIZE = 16;

   typedef logic [WORD_SIZE-1:0] word_t;

   // Increment that wraps modulo 2^WORD_SIZE.
   function automatic word_t word_inc(input word_t w);
      return word_t'(w + word_t'(1));
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests a word at pc, holds it for decode/execute,
// and advances pc to the datapath-selected target on retire.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [WORD_SIZE-1:0] RESET_PC = 16'h0000
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 read_m,
   output logic [WORD_SIZE-1:0] address,
   input  logic [WORD_SIZE-1:0] mem_data,
   input  logic                 input_ready,
   output logic [WORD_SIZE-1:0] instr,
   output logic                 instr_valid,
   output logic [WORD_SIZE-1:0] pc,
   output logic [WORD_SIZE-1:0] pc_plus1,
   input  logic [WORD_SIZE-1:0] pc_next,
   input  logic                 pc_load,
   output logic [WORD_SIZE-1:0] num_inst
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic fetch_done;
   logic retire;

   // Events are qualified by state so stray strobes are ignored.
   assign fetch_done = (state_q == FETCH) && input_ready;
   assign retire     = (state_q == VALID) && pc_load;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   if (input_ready) state_d = VALID;
         VALID:   if (pc_load) state_d = FETCH;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      read_m      = 1'b0;
      instr_valid = 1'b0;
      case (state_q)
         FETCH:   read_m = 1'b1;
         VALID:   instr_valid = 1'b1;
         default: ;
      endcase
   end

   // PC, instruction latch and retire counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= RESET_PC;
         instr    <= '0;
         num_inst <= '0;
      end else begin
         if (fetch_done) begin
            instr <= mem_data;
         end
         if (retire) begin
            pc       <= pc_next;
            num_inst <= word_inc(num_inst);
         end
      end
   end

   assign address  = pc;
   assign pc_plus1 = word_inc(pc);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
`timescale 1ns/1ps
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        read_m;
   logic [15:0] address;
   logic [15:0] mem_data;
   logic        input_ready;
   logic [15:0] instr;
   logic        instr_valid;
   logic [15:0] pc;
   logic [15:0] pc_plus1;
   logic [15:0] pc_next;
   logic        pc_load;
   logic [15:0] num_inst;

   int vec_cnt = 0;
   int err_cnt = 0;

   instr_fetch #(.RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .read_m      (read_m),
      .address     (address),
      .mem_data    (mem_data),
      .input_ready (input_ready),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus1    (pc_plus1),
      .pc_next     (pc_next),
      .pc_load     (pc_load),
      .num_inst    (num_inst)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rst, input logic rdy, input logic [15:0] md,
                        input logic ld, input logic [15:0] nx);
      reset       = rst;
      input_ready = rdy;
      mem_data    = md;
      pc_load     = ld;
      pc_next     = nx;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
      tick();
      tick();
      vec_cnt++;
      if ({read_m, instr_valid} !== 2'b00) begin
         err_cnt++;
         $display("FAIL reset_ctrl: got %b expected 00", {read_m, instr_valid});
      end
      vec_cnt++;
      if ({pc, instr, num_inst} !== 48'h0) begin
         err_cnt++;
         $display("FAIL reset_regs: pc=%h instr=%h num=%h expected all 0000", pc, instr, num_inst);
      end
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      tick();
      vec_cnt++;
      if (read_m !== 1'b1 || address !== 16'h0000 || instr_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL first_fetch: read_m=%b addr=%h valid=%b expected 1 0000 0",
                  read_m, address, instr_valid);
      end
   endtask

   task automatic test_zero_wait();
      drive(1'b0, 1'b1, 16'h6001, 1'b0, 16'h0000);
      tick();
      vec_cnt++;
      if (instr !== 16'h6001 || instr_valid !== 1'b1 || read_m !== 1'b0) begin
         err_cnt++;
         $display("FAIL zero_wait: instr=%h valid=%b read_m=%b expected 6001 1 0",
                  instr, instr_valid, read_m);
      end
      vec_cnt++;
      if (pc_plus1 !== 16'h0001) begin
         err_cnt++;
         $display("FAIL pc_plus1: got %h expected 0001", pc_plus1);
      end
   endtask

   task automatic test_ignored_in_valid();
      drive(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000);
      tick();
      tick();
      vec_cnt++;
      if (instr !== 16'h6001 || instr_valid !== 1'b1 || pc !== 16'h0000 || num_inst !== 16'h0000) begin
         err_cnt++;
         $display("FAIL ready_in_valid: instr=%h valid=%b pc=%h num=%h expected 6001 1 0000 0000",
                  instr, instr_valid, pc, num_inst);
      end
   endtask

   task automatic test_branch();
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040);
      tick();
      vec_cnt++;
      if (read_m !== 1'b1 || address !== 16'h0040 || pc !== 16'h0040 ||
          num_inst !== 16'h0001 || instr_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL branch: read_m=%b addr=%h pc=%h num=%h valid=%b expected 1 0040 0040 0001 0",
                  read_m, address, pc, num_inst, instr_valid);
      end
   endtask

   task automatic test_wait_states();
      // Stray pc_load during FETCH must not retire anything.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 16'hDEAD, 1'b1, 16'h1234);
         tick();
         vec_cnt++;
         if (read_m !== 1'b1 || address !== 16'h0040 || num_inst !== 16'h0001 || instr_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL wait_%0d: read_m=%b addr=%h num=%h valid=%b expected 1 0040 0001 0",
                     i, read_m, address, num_inst, instr_valid);
         end
      end
      drive(1'b0, 1'b1, 16'h9005, 1'b1, 16'h1234);
      tick();
      vec_cnt++;
      if (instr !== 16'h9005 || instr_valid !== 1'b1 || pc !== 16'h0040 || num_inst !== 16'h0001) begin
         err_cnt++;
         $display("FAIL wait_done: instr=%h valid=%b pc=%h num=%h expected 9005 1 0040 0001",
                  instr, instr_valid, pc, num_inst);
      end
   endtask

   task automatic test_wrap();
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF);
      tick();
      vec_cnt++;
      if (read_m !== 1'b1 || address !== 16'hFFFF || pc_plus1 !== 16'h0000 || num_inst !== 16'h0002) begin
         err_cnt++;
         $display("FAIL pc_wrap: read_m=%b addr=%h pc_plus1=%h num=%h expected 1 ffff 0000 0002",
                  read_m, address, pc_plus1, num_inst);
      end
      drive(1'b0, 1'b1, 16'h1111, 1'b0, 16'h0000);
      tick();
      vec_cnt++;
      if (instr !== 16'h1111 || instr_valid !== 1'b1) begin
         err_cnt++;
         $display("FAIL fetch_ffff: instr=%h valid=%b expected 1111 1", instr, instr_valid);
      end
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      force dut.num_inst = 16'hFFFF;
      #1;
      release dut.num_inst;
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005);
      tick();
      vec_cnt++;
      if (num_inst !== 16'h0000 || address !== 16'h0005 || read_m !== 1'b1) begin
         err_cnt++;
         $display("FAIL num_wrap: num=%h addr=%h read_m=%b expected 0000 0005 1",
                  num_inst, address, read_m);
      end
   endtask

   task automatic test_mid_fetch_reset();
      drive(1'b1, 1'b1, 16'hABCD, 1'b0, 16'h0000);
      tick();
      vec_cnt++;
      if (read_m !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0000 ||
          pc !== 16'h0000 || num_inst !== 16'h0000) begin
         err_cnt++;
         $display("FAIL mid_reset: read_m=%b valid=%b instr=%h pc=%h num=%h expected 0 0 0000 0000 0000",
                  read_m, instr_valid, instr, pc, num_inst);
      end
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      tick();
      vec_cnt++;
      if (read_m !== 1'b1 || address !== 16'h0000 || instr !== 16'h0000) begin
         err_cnt++;
         $display("FAIL refetch: read_m=%b addr=%h instr=%h expected 1 0000 0000",
                  read_m, address, instr);
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
      test_reset();
      test_zero_wait();
      test_ignored_in_valid();
      test_branch();
      test_wait_states();
      test_wrap();
      test_mid_fetch_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter RESET_PC SHALL default to 16'h0000 and give the PC value loaded on reset.
REQ-003 The ports SHALL be:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- read_m  output  1  instruction-memory read request.
- address  output  WORD_SIZE  instruction-memory address.
- mem_data  input  WORD_SIZE  instruction word from memory.
- input_ready  input  1  memory data valid, sampled only while read_m=1.
- instr  output  WORD_SIZE  latched instruction, driven to the control unit and datapath.
- instr_valid  output  1  instr is valid and held for decode/execute.
- pc  output  WORD_SIZE  address of the current instr.
- pc_plus1  output  WORD_SIZE  pc+1, mod 2^16.
- pc_next  input  WORD_SIZE  next PC selected by the datapath (sequential, branch or jump target).
- pc_load  input  1  one-cycle pulse meaning the current instruction is retired: load pc_next.
- num_inst  output  WORD_SIZE  count of retired instructions.

Function
REQ-004 The FSM SHALL have three states:
- IDLE: read_m=0, instr_valid=0.
- FETCH: read_m=1, address=pc, instr_valid=0.
- VALID: read_m=0, instr_valid=1.
REQ-005 IDLE SHALL go to FETCH unconditionally on the next clock.
REQ-006 In FETCH with input_ready=1, the block SHALL latch mem_data into instr and go to VALID; with input_ready=0 it SHALL stay in FETCH and keep read_m and address stable.
REQ-007 In VALID with pc_load=1, the block SHALL load pc<=pc_next, increment num_inst and go to FETCH; with pc_load=0 it SHALL hold instr, pc and instr_valid.
REQ-008 pc_load outside VALID SHALL be ignored, including in the same cycle as input_ready in FETCH; num_inst SHALL not change.
REQ-009 input_ready outside FETCH SHALL be ignored, and instr SHALL not change.
REQ-010 Minimum latency SHALL be 1 cycle from FETCH entry to instr_valid=1 (input_ready high in the first FETCH cycle); each extra memory wait cycle SHALL add exactly 1 cycle.
REQ-011 Retire-to-fetch SHALL take 1 cycle: the cycle after pc_load in VALID, read_m=1 with address=pc_next.
REQ-012 Wrap-around:
- pc_plus1 SHALL wrap 16'hFFFF to 16'h0000.
- num_inst SHALL wrap 16'hFFFF to 16'h0000.
- pc_next=16'hFFFF SHALL be fetched normally.
REQ-013 read_m, address, instr_valid, instr and pc SHALL be driven from registers or decoded state only, never combinationally from input_ready or mem_data.

Reset
REQ-014 When reset=1 at a clock edge, the block SHALL set state=IDLE, pc=RESET_PC, instr=16'h0000, num_inst=0, read_m=0 and instr_valid=0, regardless of current state.
REQ-015 A reset asserted during FETCH SHALL abandon the outstanding read, and any input_ready in that cycle SHALL be ignored.
REQ-016 After reset deasserts, the first read_m=1 SHALL occur exactly 1 cycle later, in FETCH with address=RESET_PC.

Structure
REQ-017 WORD_SIZE SHALL come from the shared opcodes include; the FSM state encodings SHALL be local constants of this module.
REQ-018 No sub-module is required: the PC, instruction and counter registers and the FSM SHALL be in one module.

Verification
REQ-019 Zero-wait fetch: reset 2 cycles, then input_ready=1 with mem_data=16'h6001 in the first FETCH cycle -> address=16'h0000, instr=16'h6001 and instr_valid=1 one cycle later.
REQ-020 Wait states: input_ready low for 3 FETCH cycles, then high with mem_data=16'h9005 -> read_m held 4 cycles at a constant address, then instr=16'h9005 with instr_valid=1.
REQ-021 Branch load: in VALID, pc_load=1 with pc_next=16'h0040 -> next cycle read_m=1, address=16'h0040, num_inst=1, pc=16'h0040.
REQ-022 Ignored events: pc_load=1 during FETCH, and input_ready=1 with mem_data=16'hFFFF during VALID -> num_inst, pc and instr unchanged.
REQ-023 Wrap: pc_next=16'hFFFF is loaded and fetched -> pc_plus1=16'h0000; num_inst preset to 16'hFFFF via 65535 retirements (or forced) then one pc_load -> num_inst=16'h0000.
REQ-024 Mid-fetch reset: reset=1 while in FETCH with input_ready=1 -> next cycle state IDLE, instr=16'h0000, instr_valid=0, pc=RESET_PC.
